reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single write port of the NSC-8 register bank among three write sources: 0 = ALU result, 1 = memory load, 2 = immediate/move.
- Each requester offers a register address and data through a valid/ready handshake. The block grants one requester per cycle in round-robin order.
- On the cycle after acceptance, the block drives the one-hot write_enable and the shared data_in of the N_bit_register instances in the bank.
- It also keeps a saturating contention counter that performance debug reads.

Parameters:
- N, 8, data width of each register and of every requester data bus.
- NUM_REGS, 4, number of N_bit_register instances in the bank.
- ADDR_W, 2, register address width; NUM_REGS <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  when high, no grants are issued and the round-robin pointer holds.
- req_valid  input  3  per-requester request valid; bit i belongs to requester i.
- req_addr  input  3*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  input  3*N  flattened data; requester i uses bits [i*N +: N].
- req_ready  output  3  combinational one-hot grant (at most one bit high).
- reg_we  output  NUM_REGS  registered one-hot write enables, one per register.
- reg_data  output  N  registered data to the shared data_in of all registers.
- err_addr  output  1  registered one-cycle pulse when an accepted address is >= NUM_REGS.
- contention_cnt  output  8  saturating count of cycles with two or more valid requests while not stalled.

Behaviour:
- Reset (async assert, rst_n low): reg_we=0, reg_data=0, err_addr=0, contention_cnt=0, round-robin pointer=0 (requester 0 highest priority).
- Reset release is synchronous to clk. The first grant is possible in the first cycle that rst_n is high.
- Grant (combinational):
  - If stall=1 or req_valid=0, then req_ready=0.
  - Otherwise grant the first valid requester, searching ptr, ptr+1, ptr+2 (mod 3).
  - req_ready never depends on req_addr or req_data.
- Transfer: occurs in a cycle when req_valid[i] & req_ready[i].
- Requester rule: once raised, valid, addr and data stay stable until the transfer. The arbiter does not check this.
- Pointer update: on a transfer by requester i, ptr <= (i+1) mod 3 at the clock edge. With no transfer, ptr holds.
- Output latency: a transfer in cycle T produces, in cycle T+1:
  - reg_we = one-hot of the accepted addr, high for exactly one cycle;
  - reg_data = the accepted data.
- The register itself captures the value at the end of cycle T+1, so data_out updates 2 edges after acceptance.
- No transfer in a cycle: the next cycle has reg_we=0 and reg_data holds its last value.
- Back-to-back transfers are allowed every cycle, giving full throughput of 1 write/cycle.
- Bad address: if addr >= NUM_REGS, the request is still accepted and the pointer still advances. In T+1, reg_we=0, err_addr=1 for one cycle, and reg_data updates.
- Contention counter:
  - Increments by 1 at the edge ending any cycle where stall=0 and popcount(req_valid) >= 2.
  - Saturates at 255; it never wraps.
  - Cleared only by reset.
- Stall asserted: no grants are issued. Output regs still drain, so a transfer accepted in the cycle before the stall still produces its write in the first stall cycle.
- Reset mid-operation: any pending output write is dropped immediately (reg_we forced 0 asynchronously) and the pointer returns to 0.
- Width rules: addresses are zero-extended for comparison against NUM_REGS. Data passes through unmodified; there is no arithmetic on data.

Test Plan:
- Single request: reset, then req_valid=3'b001, addr0=2, data0=8'hA5 for one cycle -> req_ready=3'b001 that cycle. Next cycle reg_we=4'b0100, reg_data=8'hA5, for one cycle only.
- Round robin: all three valid every cycle, with addrs 0/1/2 and data 11/22/33 -> grants 0,1,2,0,... on consecutive cycles. reg_we sequence 0001,0010,0100,0001. contention_cnt increases by 1 per cycle.
- Stall: all valid with stall=1 for 3 cycles -> req_ready=0, reg_we=0 after the drain cycle, pointer unchanged, contention_cnt unchanged. On deassert, the grant goes to the requester the pointer held.
- Bad address: NUM_REGS=3, requester 1 with addr=3, data=8'h5A -> accepted. Next cycle reg_we=0, err_addr=1, reg_data=8'h5A. The next grant starts at requester 2.
- Saturation: keep two requesters valid for 300 unstalled cycles -> contention_cnt reaches 255 and holds at 255.
- Async reset mid-write: pull rst_n low between the clock edges of cycle T+1 of an accepted write -> reg_we drops to 0 immediately. After release, the first grant goes to requester 0 even if requesters 1 and 2 are also valid.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Handshake and write-port bundle between the three write sources and the
// register-bank write arbiter.
interface reg_write_arbiter_if #(
  parameter int unsigned N        = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 2
);
  logic                  stall;
  logic [2:0]            req_valid;
  logic [3*ADDR_W-1:0]   req_addr;
  logic [3*N-1:0]        req_data;
  logic [2:0]            req_ready;
  logic [NUM_REGS-1:0]   reg_we;
  logic [N-1:0]          reg_data;
  logic                  err_addr;
  logic [7:0]            contention_cnt;

  // Arbiter side.
  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, reg_we, reg_data, err_addr, contention_cnt
  );

  // Requester / environment side.
  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, reg_we, reg_data, err_addr, contention_cnt
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the single register-bank write port among the
// ALU (0), memory load (1) and immediate/move (2) sources. Accepted writes
// appear one cycle later as a one-hot write enable plus shared data.
module reg_write_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_write_arbiter_if.slave  io_bus
);

  logic [1:0]          r_ptr;
  logic [1:0]          w_ptr_d;
  logic [2:0]          w_grant;
  logic [1:0]          w_sel;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_addr;
  logic [N-1:0]        w_data;
  logic                w_addr_ok;
  logic [NUM_REGS-1:0] w_we_d;
  logic                w_contend;

  logic [NUM_REGS-1:0] r_we;
  logic [N-1:0]        r_data;
  logic                r_err;
  logic [7:0]          r_cnt;

  // Grant the first valid requester starting from the round-robin pointer.
  always_comb begin
    w_grant = 3'b000;
    if (!io_bus.stall) begin
      unique case (r_ptr)
        2'd1: begin
          if      (io_bus.req_valid[1]) w_grant = 3'b010;
          else if (io_bus.req_valid[2]) w_grant = 3'b100;
          else if (io_bus.req_valid[0]) w_grant = 3'b001;
        end
        2'd2: begin
          if      (io_bus.req_valid[2]) w_grant = 3'b100;
          else if (io_bus.req_valid[0]) w_grant = 3'b001;
          else if (io_bus.req_valid[1]) w_grant = 3'b010;
        end
        default: begin
          if      (io_bus.req_valid[0]) w_grant = 3'b001;
          else if (io_bus.req_valid[1]) w_grant = 3'b010;
          else if (io_bus.req_valid[2]) w_grant = 3'b100;
        end
      endcase
    end
  end

  // Encode the grant and mux the winning address/data.
  always_comb begin
    w_sel = 2'd0;
    if (w_grant[1]) w_sel = 2'd1;
    if (w_grant[2]) w_sel = 2'd2;
    unique case (w_sel)
      2'd1: begin
        w_addr = io_bus.req_addr[ADDR_W +: ADDR_W];
        w_data = io_bus.req_data[N +: N];
      end
      2'd2: begin
        w_addr = io_bus.req_addr[2*ADDR_W +: ADDR_W];
        w_data = io_bus.req_data[2*N +: N];
      end
      default: begin
        w_addr = io_bus.req_addr[0 +: ADDR_W];
        w_data = io_bus.req_data[0 +: N];
      end
    endcase
  end

  // Grant is only ever raised for a valid requester, so any grant is a transfer.
  assign w_xfer    = |w_grant;
  assign w_addr_ok = 32'(w_addr) < NUM_REGS;
  assign w_contend = !io_bus.stall &&
                     ((io_bus.req_valid[0] && io_bus.req_valid[1]) ||
                      (io_bus.req_valid[0] && io_bus.req_valid[2]) ||
                      (io_bus.req_valid[1] && io_bus.req_valid[2]));

  // Decode the accepted address into a one-hot enable; out-of-range decodes to zero.
  always_comb begin
    w_we_d = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_we_d[r] = w_xfer && (32'(w_addr) == r);
    end
  end

  // Next pointer: the requester after the one just served.
  always_comb begin
    w_ptr_d = r_ptr;
    if (w_xfer) begin
      unique case (w_sel)
        2'd1:    w_ptr_d = 2'd2;
        2'd2:    w_ptr_d = 2'd0;
        default: w_ptr_d = 2'd1;
      endcase
    end
  end

  // Pointer, registered write port, error pulse and saturating contention count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= 2'd0;
      r_we   <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_cnt  <= 8'd0;
    end else begin
      r_ptr <= w_ptr_d;
      r_we  <= w_we_d;
      r_err <= w_xfer && !w_addr_ok;
      if (w_xfer) begin
        r_data <= w_data;
      end
      if (w_contend && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign io_bus.req_ready      = w_grant;
  assign io_bus.reg_we         = r_we;
  assign io_bus.reg_data       = r_data;
  assign io_bus.err_addr       = r_err;
  assign io_bus.contention_cnt = r_cnt;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a 4-register instance for the main
// scenarios and a 3-register instance for out-of-range addresses, both fed
// the same stimulus.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [2:0]  valid;
  logic [5:0]  addr;
  logic [23:0] data;

  int checks;
  int errors;

  reg_write_arbiter_if #(.N(8), .NUM_REGS(4), .ADDR_W(2)) bus4 ();
  reg_write_arbiter_if #(.N(8), .NUM_REGS(3), .ADDR_W(2)) bus3 ();

  assign bus4.stall     = stall;
  assign bus4.req_valid = valid;
  assign bus4.req_addr  = addr;
  assign bus4.req_data  = data;
  assign bus3.stall     = stall;
  assign bus3.req_valid = valid;
  assign bus3.req_addr  = addr;
  assign bus3.req_data  = data;

  reg_write_arbiter #(.N(8), .NUM_REGS(4), .ADDR_W(2)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus4)
  );

  reg_write_arbiter #(.N(8), .NUM_REGS(3), .ADDR_W(2)) dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rr_rdy  [5];
  logic [3:0] rr_we   [4];
  logic [7:0] rr_data [4];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    valid = 3'b000;
    addr  = '0;
    data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    valid = 3'b000;
    addr  = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus4.reg_we !== 4'b0000) begin
      errors++;
      $display("FAIL reset_we: got %b expected 0000", bus4.reg_we);
    end
    checks++;
    if (bus4.reg_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", bus4.reg_data);
    end
    checks++;
    if (bus4.err_addr !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", bus4.err_addr);
    end
    checks++;
    if (bus4.contention_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", bus4.contention_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    valid = 3'b001;
    addr  = 6'b00_00_10;
    data  = 24'h0000A5;
    #1;
    checks++;
    if (bus4.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL single_ready: got %b expected 001", bus4.req_ready);
    end
    @(negedge clk);
    valid = 3'b000;
    #1;
    checks++;
    if (bus4.reg_we !== 4'b0100) begin
      errors++;
      $display("FAIL single_we: got %b expected 0100", bus4.reg_we);
    end
    checks++;
    if (bus4.reg_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h expected a5", bus4.reg_data);
    end
    checks++;
    if (bus4.req_ready !== 3'b000) begin
      errors++;
      $display("FAIL single_idle_ready: got %b expected 000", bus4.req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus4.reg_we !== 4'b0000) begin
      errors++;
      $display("FAIL single_we_one_cycle: got %b expected 0000", bus4.reg_we);
    end
    checks++;
    if (bus4.reg_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data_hold: got %h expected a5", bus4.reg_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    valid = 3'b111;
    addr  = 6'b10_01_00;
    data  = 24'h332211;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus4.req_ready !== rr_rdy[k]) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus4.req_ready, rr_rdy[k]);
      end
      checks++;
      if (bus4.contention_cnt !== 8'(k)) begin
        errors++;
        $display("FAIL rr_cnt[%0d]: got %0d expected %0d", k, bus4.contention_cnt, k);
      end
      if (k > 0) begin
        checks++;
        if (bus4.reg_we !== rr_we[k-1]) begin
          errors++;
          $display("FAIL rr_we[%0d]: got %b expected %b", k, bus4.reg_we, rr_we[k-1]);
        end
        checks++;
        if (bus4.reg_data !== rr_data[k-1]) begin
          errors++;
          $display("FAIL rr_data[%0d]: got %h expected %h", k, bus4.reg_data, rr_data[k-1]);
        end
      end
      @(negedge clk);
    end
    valid = 3'b000;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    valid = 3'b111;
    addr  = 6'b10_01_00;
    data  = 24'h332211;
    #1;
    checks++;
    if (bus4.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL stall_pre_ready: got %b expected 001", bus4.req_ready);
    end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      checks++;
      if (bus4.req_ready !== 3'b000) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b expected 000", s, bus4.req_ready);
      end
      checks++;
      if (bus4.reg_we !== ((s == 0) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL stall_we[%0d]: got %b expected %b", s, bus4.reg_we,
                 (s == 0) ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (bus4.contention_cnt !== 8'd1) begin
        errors++;
        $display("FAIL stall_cnt[%0d]: got %0d expected 1", s, bus4.contention_cnt);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    checks++;
    if (bus4.req_ready !== 3'b010) begin
      errors++;
      $display("FAIL stall_resume_ready: got %b expected 010", bus4.req_ready);
    end
    @(negedge clk);
    valid = 3'b000;
    #1;
    checks++;
    if (bus4.reg_we !== 4'b0010) begin
      errors++;
      $display("FAIL stall_resume_we: got %b expected 0010", bus4.reg_we);
    end
    checks++;
    if (bus4.contention_cnt !== 8'd2) begin
      errors++;
      $display("FAIL stall_resume_cnt: got %0d expected 2", bus4.contention_cnt);
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    @(negedge clk);
    valid = 3'b010;
    addr  = 6'b00_11_00;
    data  = 24'h005A00;
    #1;
    checks++;
    if (bus3.req_ready !== 3'b010) begin
      errors++;
      $display("FAIL bad_ready: got %b expected 010", bus3.req_ready);
    end
    @(negedge clk);
    valid = 3'b111;
    addr  = 6'b01_11_00;
    data  = 24'hC35A3C;
    #1;
    checks++;
    if (bus3.req_ready !== 3'b100) begin
      errors++;
      $display("FAIL bad_next_ready: got %b expected 100", bus3.req_ready);
    end
    checks++;
    if (bus3.reg_we !== 3'b000) begin
      errors++;
      $display("FAIL bad_we: got %b expected 000", bus3.reg_we);
    end
    checks++;
    if (bus3.err_addr !== 1'b1) begin
      errors++;
      $display("FAIL bad_err: got %b expected 1", bus3.err_addr);
    end
    checks++;
    if (bus3.reg_data !== 8'h5A) begin
      errors++;
      $display("FAIL bad_data: got %h expected 5a", bus3.reg_data);
    end
    checks++;
    if ((bus4.reg_we !== 4'b1000) || (bus4.err_addr !== 1'b0)) begin
      errors++;
      $display("FAIL addr3_in_range: got we=%b err=%b expected we=1000 err=0",
               bus4.reg_we, bus4.err_addr);
    end
    @(negedge clk);
    valid = 3'b000;
    #1;
    checks++;
    if (bus3.err_addr !== 1'b0) begin
      errors++;
      $display("FAIL bad_err_pulse: got %b expected 0", bus3.err_addr);
    end
    checks++;
    if ((bus3.reg_we !== 3'b010) || (bus3.reg_data !== 8'hC3)) begin
      errors++;
      $display("FAIL bad_after_write: got we=%b data=%h expected we=010 data=c3",
               bus3.reg_we, bus3.reg_data);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    valid = 3'b011;
    addr  = 6'b00_01_00;
    data  = 24'h000201;
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (bus4.contention_cnt !== 8'd100) begin
      errors++;
      $display("FAIL sat_cnt_100: got %0d expected 100", bus4.contention_cnt);
    end
    repeat (200) @(negedge clk);
    #1;
    checks++;
    if (bus4.contention_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_cnt_300: got %0d expected 255", bus4.contention_cnt);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus4.contention_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_cnt_hold: got %0d expected 255", bus4.contention_cnt);
    end
    valid = 3'b000;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    valid = 3'b001;
    addr  = 6'b10_01_01;
    data  = 24'h333377;
    #1;
    checks++;
    if (bus4.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL arst_ready: got %b expected 001", bus4.req_ready);
    end
    @(negedge clk);
    valid = 3'b111;
    #1;
    checks++;
    if ((bus4.reg_we !== 4'b0010) || (bus4.reg_data !== 8'h77)) begin
      errors++;
      $display("FAIL arst_pre_write: got we=%b data=%h expected we=0010 data=77",
               bus4.reg_we, bus4.reg_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ((bus4.reg_we !== 4'b0000) || (bus4.reg_data !== 8'h00)) begin
      errors++;
      $display("FAIL arst_drop: got we=%b data=%h expected we=0000 data=00",
               bus4.reg_we, bus4.reg_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus4.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL arst_first_grant: got %b expected 001", bus4.req_ready);
    end
    @(negedge clk);
    valid = 3'b000;
    #1;
    checks++;
    if ((bus4.reg_we !== 4'b0010) || (bus4.reg_data !== 8'h77)) begin
      errors++;
      $display("FAIL arst_post_write: got we=%b data=%h expected we=0010 data=77",
               bus4.reg_we, bus4.reg_data);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rr_rdy  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    rr_we   = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
    rr_data = '{8'h11, 8'h22, 8'h33, 8'h11};
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_bad_addr();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
